// File: rtl/ahb_arb_pkg.sv
// ahb_arb_pkg: shared constants and types for the AHB round-robin arbiter.
//   - HTRANS / HRESP encodings
//   - arbiter state encoding (ARB, LOCKED)
//   - MAX_MST: widest master vector the arbiter supports
package ahb_arb_pkg;

    localparam int MAX_MST = 16;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;
    localparam logic [1:0] HRESP_RETRY = 2'b10;
    localparam logic [1:0] HRESP_SPLIT = 2'b11;

    typedef enum logic [0:0] {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/ahb_rr_pick.sv
// ahb_rr_pick: combinational rotating priority encoder.
// Searches i_eligible starting at i_ptr+1, wrapping at NMST-1 -> 0, and
// finishing at i_ptr itself.
// Ports:
//   i_eligible [NMST-1:0]  candidate masters
//   i_ptr      [3:0]       index of the last master granted
//   o_found                at least one candidate exists
//   o_idx      [3:0]       first candidate in rotating order (0 if none)
module ahb_rr_pick
    import ahb_arb_pkg::*;
#(
    parameter int NMST = 16
) (
    input  logic [NMST-1:0] i_eligible,
    input  logic [3:0]      i_ptr,
    output logic            o_found,
    output logic [3:0]      o_idx
);

    logic [MAX_MST-1:0] w_elig_x;
    int                 w_cand;

    assign w_elig_x = MAX_MST'(i_eligible);

    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_cand  = 0;
        for (int k = 1; k <= NMST; k++) begin
            w_cand = (int'(i_ptr) + k) % NMST;
            if (!o_found && w_elig_x[w_cand[3:0]]) begin
                o_found = 1'b1;
                o_idx   = w_cand[3:0];
            end
        end
    end

endmodule

// File: rtl/ahb_rr_arbiter.sv
// ahb_rr_arbiter: round-robin AHB bus arbiter for up to 16 masters with
// locked-transfer support, split masking and default-master parking.
// Optional feature macro: AHB_ARB_BURST_HOLD_EN (hold the grant while
// HTRANS=SEQ in the ARB state; SPLIT still forces re-arbitration).
// Ports:
//   HCLK, HRESETn        clock, asynchronous active-low reset
//   HBUSREQx [NMST]      bus requests
//   HLOCKx   [NMST]      locked-transfer requests
//   HSPLIT   [NMST]      split release, bit i unmasks master i
//   HREADY               transfer complete / handover strobe
//   HRESP    [2]         slave response
//   HTRANS   [2]         transfer type (burst-hold feature only)
//   HGRANTx  [NMST]      registered one-hot grant
//   HMASTER  [4]         registered address-phase owner
//   HMASTLOCK            registered locked-sequence flag
//   o_dbg_state          current arbiter state
//   o_dbg_mask [NMST]    current split mask
//
// Handshake: every register except the split mask advances only on edges
// where HREADY=1; the split mask clears on any edge where HSPLIT is high.
module ahb_rr_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int NMST    = 16,
    parameter int DEF_MST = 0
) (
    input  logic            HCLK,
    input  logic            HRESETn,
    input  logic [NMST-1:0] HBUSREQx,
    input  logic [NMST-1:0] HLOCKx,
    input  logic [NMST-1:0] HSPLIT,
    input  logic            HREADY,
    input  logic [1:0]      HRESP,
    input  logic [1:0]      HTRANS,
    output logic [NMST-1:0] HGRANTx,
    output logic [3:0]      HMASTER,
    output logic            HMASTLOCK,
    output arb_state_e      o_dbg_state,
    output logic [NMST-1:0] o_dbg_mask
);

    localparam logic [3:0] DEF_IDX = 4'(DEF_MST);

    arb_state_e      r_state;
    logic [NMST-1:0] r_grant;
    logic [3:0]      r_gidx;
    logic [3:0]      r_hmaster;
    logic            r_mastlock;
    logic [3:0]      r_downer;
    logic [3:0]      r_ptr;
    logic [NMST-1:0] r_mask;

    logic [MAX_MST-1:0] w_lock_x;
    logic [MAX_MST-1:0] w_req_x;
    logic               w_split;
    logic [NMST-1:0]    w_split_set;
    logic [NMST-1:0]    w_elig;
    logic               w_hold;
    logic               w_cur_keep;
    logic               w_rearb;
    logic               w_found;
    logic [3:0]         w_pick_idx;
    logic [3:0]         w_next_gidx;

    assign w_lock_x = MAX_MST'(HLOCKx);
    assign w_req_x  = MAX_MST'(HBUSREQx);

    // SPLIT is acted on in its second cycle, the one with HREADY=1.
    assign w_split = HREADY && (HRESP == HRESP_SPLIT);

    // The default master is never masked so the bus always has a parking owner.
    assign w_split_set = (w_split && (r_downer != DEF_IDX)) ? (NMST'(1) << r_downer) : '0;

    // A master being split on this very edge is already excluded, so it
    // cannot be handed the bus in the same cycle its slave rejected it.
    assign w_elig = HBUSREQx & ~(r_mask | w_split_set);

`ifdef AHB_ARB_BURST_HOLD_EN
    assign w_hold = (HTRANS == HTRANS_SEQ);
`else
    logic w_unused_htrans;
    assign w_unused_htrans = ^HTRANS;
    assign w_hold = 1'b0;
`endif

    // A locked owner keeps the bus while it still requests with HLOCK high.
    assign w_cur_keep = w_lock_x[r_gidx] && w_req_x[r_gidx];

    assign w_rearb = HREADY && (w_split ||
                     ((r_state == ST_ARB) ? !w_hold : !w_cur_keep));

    ahb_rr_pick #(.NMST(NMST)) u_pick (
        .i_eligible (w_elig),
        .i_ptr      (r_ptr),
        .o_found    (w_found),
        .o_idx      (w_pick_idx)
    );

    assign w_next_gidx = w_found ? w_pick_idx : DEF_IDX;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state    <= ST_ARB;
            r_grant    <= NMST'(1) << DEF_IDX;
            r_gidx     <= DEF_IDX;
            r_hmaster  <= DEF_IDX;
            r_mastlock <= 1'b0;
            r_downer   <= DEF_IDX;
            r_ptr      <= DEF_IDX;
            r_mask     <= '0;
        end else begin
            // Set wins over a coincident release of the same bit.
            r_mask <= (r_mask & ~HSPLIT) | w_split_set;
            if (HREADY) begin
                r_hmaster  <= r_gidx;
                r_mastlock <= w_lock_x[r_gidx];
                r_downer   <= r_hmaster;
                if (w_rearb) begin
                    r_gidx  <= w_next_gidx;
                    r_grant <= NMST'(1) << w_next_gidx;
                    if (w_found) begin
                        r_ptr <= w_pick_idx;
                    end
                    r_state <= w_lock_x[w_next_gidx] ? ST_LOCKED : ST_ARB;
                end
            end
        end
    end

    assign HGRANTx     = r_grant;
    assign HMASTER     = r_hmaster;
    assign HMASTLOCK   = r_mastlock;
    assign o_dbg_state = r_state;
    assign o_dbg_mask  = r_mask;

endmodule
